// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared op codes, FSM state encoding and op-class helper for the
//             execute-stage ALU.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_NOR  = 4'b0100;
   localparam logic [3:0] ALU_SLTU = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SLLV = 4'b1001;
   localparam logic [3:0] ALU_SRL  = 4'b1010;
   localparam logic [3:0] ALU_SRLV = 4'b1011;
   localparam logic [3:0] ALU_SRA  = 4'b1100;
   localparam logic [3:0] ALU_SRAV = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_t;

   // Shift codes are 1000..1101; 1110/1111 are undefined.
   function automatic logic is_shift_op(input logic [3:0] op);
      return op[3] & ~(op[2] & op[1]);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_shift_iter.sv
// ============================================================================
//  Module   : alu_shift_iter
//  Purpose  : Iterative one-bit-per-cycle shifter with down-counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_shift_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             left_i,
   input  logic             arith_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic [4:0]       amount_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   logic [WIDTH-1:0] work_q;
   logic [4:0]       cnt_q;
   logic             left_q;
   logic             arith_q;
   logic [WIDTH-1:0] w_step;

   // result_o is the value after the step taken this cycle, so the last
   // shift can be captured by the parent on the same edge it happens.
   assign w_step   = left_q ? {work_q[WIDTH-2:0], 1'b0}
                            : {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
   assign result_o = w_step;
   assign done_o   = (cnt_q == 5'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q  <= '0;
         cnt_q   <= 5'd0;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
      end else if (start_i) begin
         work_q  <= data_i;
         cnt_q   <= amount_i;
         left_q  <= left_i;
         arith_q <= arith_i;
      end else if (cnt_q != 5'd0) begin
         work_q  <= w_step;
         cnt_q   <= cnt_q - 5'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Multi-cycle execute ALU with valid/ready handshake on both sides.
//             ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter instead
//             of the iterative one.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal
);

   alu_state_t       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             ill_q, ill_d;

   logic             w_accept;
   logic             w_go_shift;
   logic [4:0]       w_amount;
   logic             w_left;
   logic             w_arith;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_shift_imm;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_ovf;
   logic             w_alu_ill;

   assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
   assign w_accept  = in_valid & in_ready;
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign illegal   = ill_q;

   // Odd shift codes take the amount from a[4:0], even ones from shamt.
   assign w_amount = alu_op[0] ? a[4:0] : shamt;
   assign w_left   = (alu_op[2:1] == 2'b00);
   assign w_arith  = (alu_op[2:1] == 2'b10);
   assign w_sum    = a + b;
   assign w_diff   = a - b;

`ifdef ALU_FAST_SHIFT_EN
   assign w_go_shift = 1'b0;

   always_comb begin
      w_shift_imm = b >> w_amount;
      if (w_left)
         w_shift_imm = b << w_amount;
      else if (w_arith)
         w_shift_imm = $signed(b) >>> w_amount;
   end
`else
   logic             w_shift_done;
   logic [WIDTH-1:0] w_shift_res;

   // A zero-amount shift never enters SHIFT; its result is b unchanged.
   assign w_go_shift  = w_accept & is_shift_op(alu_op) & (w_amount != 5'd0);
   assign w_shift_imm = b;

   alu_shift_iter #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (w_go_shift),
      .left_i   (w_left),
      .arith_i  (w_arith),
      .data_i   (b),
      .amount_i (w_amount),
      .done_o   (w_shift_done),
      .result_o (w_shift_res)
   );
`endif

   always_comb begin
      w_alu_res = '0;
      w_alu_ovf = 1'b0;
      w_alu_ill = 1'b0;
      case (alu_op)
         ALU_AND:  w_alu_res = a & b;
         ALU_OR:   w_alu_res = a | b;
         ALU_XOR:  w_alu_res = a ^ b;
         ALU_NOR:  w_alu_res = ~(a | b);
         ALU_ADD: begin
            w_alu_res = w_sum;
            w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            w_alu_res = w_diff;
            w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLL, ALU_SLLV, ALU_SRL, ALU_SRLV, ALU_SRA, ALU_SRAV:
                   w_alu_res = w_shift_imm;
         default:  w_alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      ill_d    = ill_q;
      case (state_q)
         ST_SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
            if (w_shift_done) begin
               state_d  = ST_DONE;
               result_d = w_shift_res;
               zero_d   = (w_shift_res == '0);
               ovf_d    = 1'b0;
               ill_d    = 1'b0;
            end
`endif
         end
         default: begin
            if ((state_q == ST_DONE) && out_ready)
               state_d = ST_IDLE;
            // Accepting from DONE follows the IDLE rules in the same cycle.
            if (w_accept) begin
               if (w_go_shift) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d  = ST_DONE;
                  result_d = w_alu_res;
                  zero_d   = (w_alu_res == '0);
                  ovf_d    = w_alu_ovf;
                  ill_d    = w_alu_ill;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         ill_q    <= ill_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Directed self-checking bench for alu_exec_unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [3:0]  alu_op = 4'h0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [4:0]  shamt = '0;
   logic        in_ready, out_valid, zero, overflow, illegal;
   logic [31:0] result;

   int tests  = 0;
   int failed = 0;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .a         (a),
      .b         (b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] va;
      logic [31:0] vb;
      logic [4:0]  sh;
      logic [31:0] res;
      logic        z;
      logic        ovf;
      logic        ill;
      int          lat;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one request from #1 after an edge; wait (bounded) for out_valid.
   task automatic run_vec(input vec_t v, input int idx);
      int cyc;
      int exp_lat;
      alu_op = v.op; a = v.va; b = v.vb; shamt = v.sh; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; alu_op = 4'h0; a = ~v.va; b = ~v.vb; shamt = ~v.sh;
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
`ifdef ALU_FAST_SHIFT_EN
      exp_lat = 1;
`else
      exp_lat = v.lat;
`endif
      check($sformatf("v%0d latency", idx), cyc, exp_lat);
      check($sformatf("v%0d result", idx), result, v.res);
      check($sformatf("v%0d zero", idx), {31'd0, zero}, {31'd0, v.z});
      check($sformatf("v%0d overflow", idx), {31'd0, overflow}, {31'd0, v.ovf});
      check($sformatf("v%0d illegal", idx), {31'd0, illegal}, {31'd0, v.ill});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      vecs[0]  = '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b1, 1'b0, 1};
      vecs[1]  = '{ALU_SUB,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b0, 1};
      vecs[2]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0, 1'b0, 1};
      vecs[3]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b0, 1};
      vecs[4]  = '{ALU_SRA,  32'h0000_0000, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0, 1'b0, 5};
      vecs[5]  = '{ALU_SRAV, 32'h0000_0024, 32'h8000_0000, 5'd0,  32'hF800_0000, 1'b0, 1'b0, 1'b0, 5};
      vecs[6]  = '{ALU_SLLV, 32'h0000_0020, 32'h0000_1234, 5'd7,  32'h0000_1234, 1'b0, 1'b0, 1'b0, 1};
      vecs[7]  = '{ALU_SRL,  32'h0000_0000, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32};
      vecs[8]  = '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0, 1'b0, 1'b0, 1};
      vecs[9]  = '{ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1};
      vecs[10] = '{ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1};
      vecs[11] = '{ALU_NOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h000F_000F, 1'b0, 1'b0, 1'b0, 1};
      vecs[12] = '{ALU_SUB,  32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1};
      vecs[13] = '{ALU_SLL,  32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32};
      vecs[14] = '{4'b1110,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 1};
      vecs[15] = '{4'b1111,  32'h1234_5678, 32'h0000_0003, 5'd2,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 1};
      vecs[16] = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b0, 1};
      vecs[17] = '{ALU_SLL,  32'h0000_0000, 32'h0000_ABCD, 5'd0,  32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 1};
      vecs[18] = '{ALU_SRLV, 32'h0000_0003, 32'h0000_0080, 5'd0,  32'h0000_0010, 1'b0, 1'b0, 1'b0, 4};
      vecs[19] = '{ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b0, 1};
      vecs[20] = '{ALU_ADD,  32'h8000_0000, 32'h8000_0000, 5'd0,  32'h0000_0000, 1'b1, 1'b1, 1'b0, 1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset result", result, 32'd0);
      check("reset flags", {29'd0, zero, overflow, illegal}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++)
         run_vec(vecs[i], i);

      // Consumer stalls for 3 cycles in DONE
      @(posedge clk); #1;
      out_ready = 1'b0;
      alu_op = ALU_ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold first valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         a = $urandom; b = $urandom;
         @(posedge clk); #1;
         check($sformatf("hold%0d result", i), result, 32'd7);
         check($sformatf("hold%0d in_ready", i), {31'd0, in_ready}, 32'd0);
         check($sformatf("hold%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      alu_op = ALU_AND; a = 32'hC; b = 32'hA; in_valid = 1'b1;
      #1;
      check("release in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      check("same-edge accept valid", {31'd0, out_valid}, 32'd1);
      check("same-edge accept result", result, 32'h8);

      // Back-to-back one op per cycle
      for (int i = 0; i < 4; i++) begin
         alu_op = ALU_ADD; a = 32'(i * 100); b = 32'd7; in_valid = 1'b1;
         @(posedge clk); #1;
         check($sformatf("b2b%0d valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("b2b%0d result", i), result, 32'(i * 100 + 7));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of SLL by 20
      alu_op = ALU_SLL; a = 32'd0; b = 32'd1; shamt = 5'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid-shift out_valid", {31'd0, out_valid}, 32'd0);
      check("mid-shift in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort in_ready", {31'd0, in_ready}, 32'd1);
      check("abort out_valid", {31'd0, out_valid}, 32'd0);
      check("abort result", result, 32'd0);
      check("abort flags", {29'd0, zero, overflow, illegal}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      check("abort no out_valid pulse", 32'(seen), 32'd0);

      // Unit still operates after the abort
      run_vec(vecs[0], 100);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
